// File: rtl/raster_scan_ctrl.sv
// Raster scan sequencer: walks one triangle's clipped bbox row-major at 1 px/clk and
// registers visible pixels into a 1-deep fragment stage. Optional stats: RASTER_SCAN_STATS_EN.
module raster_scan_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [8:0]         tri_ax,
  input  logic [6:0]         tri_ay,
  input  logic signed [7:0]  tri_abx,
  input  logic signed [8:0]  tri_aby,
  input  logic [6:0]         tri_bz,
  input  logic signed [7:0]  tri_acx,
  input  logic signed [8:0]  tri_acy,
  input  logic [6:0]         tri_cz,
  input  logic [9:0]         bb_xmin,
  input  logic [9:0]         bb_xmax,
  input  logic [9:0]         bb_ymin,
  input  logic [9:0]         bb_ymax,
  input  logic               flush,
  output logic [8:0]         r_ax,
  output logic [6:0]         r_ay,
  output logic signed [7:0]  r_abx,
  output logic signed [8:0]  r_aby,
  output logic [6:0]         r_bz,
  output logic signed [7:0]  r_acx,
  output logic signed [8:0]  r_acy,
  output logic [6:0]         r_cz,
  output logic [9:0]         r_x,
  output logic [9:0]         r_y,
  input  logic [17:0]        r_uw,
  input  logic [17:0]        r_vw,
  input  logic [17:0]        r_ww,
  input  logic [18:0]        r_aw,
  input  logic               r_visible,
  output logic               frag_valid,
  input  logic               frag_ready,
  output logic [9:0]         frag_x,
  output logic [9:0]         frag_y,
  output logic [17:0]        frag_uw,
  output logic [17:0]        frag_vw,
  output logic [17:0]        frag_ww,
  output logic [18:0]        frag_aw,
  output logic               done
`ifdef RASTER_SCAN_STATS_EN
  ,
  output logic [19:0]        stat_tested,
  output logic [19:0]        stat_frags
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

  localparam logic [9:0] X_LAST = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LAST = 10'(SCREEN_H - 1);

  state_e      state_q;
  logic        tri_ready_q, frag_valid_q, done_q;
  logic [9:0]  x_q, y_q, xmin_q, xe_q, ye_q;
  logic [8:0]  ax_q;
  logic [6:0]  ay_q, bz_q, cz_q;
  logic signed [7:0] abx_q, acx_q;
  logic signed [8:0] aby_q, acy_q;
  logic [9:0]  fx_q, fy_q;
  logic [17:0] fuw_q, fvw_q, fww_q;
  logic [18:0] faw_q;

  logic [9:0]  xe_d, ye_d;
  logic        empty_d, adv, accept, frag_fire;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    xe_d      = (bb_xmax > X_LAST) ? X_LAST : bb_xmax;
    ye_d      = (bb_ymax > Y_LAST) ? Y_LAST : bb_ymax;
    empty_d   = (bb_xmin > xe_d) || (bb_ymin > ye_d);
    adv       = !frag_valid_q || frag_ready;
    accept    = (state_q == S_IDLE) && tri_valid;
    frag_fire = frag_valid_q && frag_ready;
  end

  // NOTE: state uses non-blocking assignments only, so every branch reads pre-edge values.
  // Payload and setup flops are reset too, since downstream may sample them straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tri_ready_q  <= 1'b1;
      frag_valid_q <= 1'b0;
      done_q       <= 1'b0;
      x_q <= '0;  y_q <= '0;  xmin_q <= '0;  xe_q <= '0;  ye_q <= '0;
      ax_q <= '0; ay_q <= '0; abx_q <= '0; aby_q <= '0;
      bz_q <= '0; acx_q <= '0; acy_q <= '0; cz_q <= '0;
      fx_q <= '0; fy_q <= '0; fuw_q <= '0; fvw_q <= '0; fww_q <= '0; faw_q <= '0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      tri_ready_q  <= 1'b1;
      frag_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ax_q <= tri_ax;   ay_q <= tri_ay;   abx_q <= tri_abx; aby_q <= tri_aby;
            bz_q <= tri_bz;   acx_q <= tri_acx; acy_q <= tri_acy; cz_q <= tri_cz;
            x_q         <= bb_xmin;
            y_q         <= bb_ymin;
            xmin_q      <= bb_xmin;
            xe_q        <= xe_d;
            ye_q        <= ye_d;
            tri_ready_q <= 1'b0;
            if (empty_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (adv) begin
            fx_q <= x_q;    fy_q <= y_q;
            fuw_q <= r_uw;  fvw_q <= r_vw;  fww_q <= r_ww;  faw_q <= r_aw;
            frag_valid_q <= r_visible;
            // The last pixel holds the counters so they never step past xe/ye.
            if (x_q == xe_q) begin
              if (y_q == ye_q) begin
                state_q <= S_DRAIN;
              end else begin
                x_q <= xmin_q;
                y_q <= y_q + 10'd1;
              end
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        S_DRAIN: begin
          if (adv) begin
            frag_valid_q <= 1'b0;
            state_q      <= S_DONE;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          tri_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef RASTER_SCAN_STATS_EN
  logic [19:0] tested_q, frags_q;

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (&v) ? v : v + 20'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tested_q <= '0;
      frags_q  <= '0;
    end else if (flush || accept) begin
      tested_q <= '0;
      frags_q  <= '0;
    end else begin
      if ((state_q == S_SCAN) && adv) tested_q <= sat_inc(tested_q);
      if (frag_fire)                  frags_q  <= sat_inc(frags_q);
    end
  end

  assign stat_tested = tested_q;
  assign stat_frags  = frags_q;
`else
  logic unused_fire;
  assign unused_fire = frag_fire;
`endif

  assign tri_ready  = tri_ready_q;
  assign frag_valid = frag_valid_q;
  assign done       = done_q;
  assign r_x   = x_q;    assign r_y   = y_q;
  assign r_ax  = ax_q;   assign r_ay  = ay_q;   assign r_abx = abx_q; assign r_aby = aby_q;
  assign r_bz  = bz_q;   assign r_acx = acx_q;  assign r_acy = acy_q; assign r_cz  = cz_q;
  assign frag_x  = fx_q;  assign frag_y  = fy_q;
  assign frag_uw = fuw_q; assign frag_vw = fvw_q; assign frag_ww = fww_q; assign frag_aw = faw_q;

endmodule
